// File: rtl/gf3_rs_syndrome_seq.sv
// Serial Reed-Solomon syndrome sequencer over GF(2^3), prim poly x^3+x+1, alpha=3'b010.
// Horner update per symbol: S_j <= S_j*alpha^j + r, first symbol is the highest-degree coefficient.
// Optional single-error locator outputs are built when GF3_SYN_ERRLOC_EN is defined (requires NSYN==2).

// GF(2^3) addition: carry-less, bitwise XOR
module gf_add_3 (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic [2:0] y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module gf3_rs_syndrome_seq #(
    parameter int unsigned N_SYM = 7,
    parameter int unsigned NSYN  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [2:0]        sym_data,
    output logic              syn_valid,
    input  logic              syn_ready,
    output logic [3*NSYN-1:0] syn_data,
    output logic              syn_nz
`ifdef GF3_SYN_ERRLOC_EN
    ,
    output logic [2:0]        err_pos,
    output logic [2:0]        err_mag,
    output logic [0:0]        err_unc
`endif
);

    localparam int unsigned CNT_W = $clog2(N_SYM + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NSYN-1:0][2:0]     s_q, s_d, s_mul, s_upd;
    logic                     syn_valid_q;
    logic [3*NSYN-1:0]        syn_data_q;
    logic                     syn_nz_q;
    logic                     accept;
    logic                     cap;

    // Multiply by alpha, reducing with x^3 = x+1
    function automatic logic [2:0] xtime(input logic [2:0] b);
        return {b[1], b[0] ^ b[2], b[2]};
    endfunction

    // Multiply by alpha^n through n chained xtime stages
    function automatic logic [2:0] xtime_pow(input logic [2:0] s, input int unsigned n);
        logic [2:0] v;
        v = s;
        for (int unsigned i = 0; i < NSYN; i++) begin
            if (i < n) v = xtime(v);
        end
        return v;
    endfunction

    // Per-syndrome Horner datapath
    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        assign s_mul[j] = xtime_pow(s_q[j], j + 1);
        gf_add_3 u_add (.a_i(s_mul[j]), .b_i(sym_data), .y_o(s_upd[j]));
    end

    // Next-state, accept handshake and syndrome update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        cap       = 1'b0;
        sym_ready = (state_q != ST_DONE) || syn_ready;
        accept    = sym_valid && sym_ready;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if ((state_q == ST_DONE) && syn_ready) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            if (accept) begin
                if (state_q == ST_ACC) begin
                    s_d   = s_upd;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(N_SYM)) begin
                        state_d = ST_DONE;
                        cap     = 1'b1;
                    end
                end else begin
                    s_d     = {NSYN{sym_data}};
                    cnt_d   = CNT_W'(1);
                    state_d = ST_ACC;
                end
            end
        end
    end

    // State, accumulators and presented result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_q         <= '0;
            syn_valid_q <= 1'b0;
            syn_data_q  <= '0;
            syn_nz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            syn_valid_q <= (state_d == ST_DONE);
            if (cap) begin
                syn_data_q <= s_d;
                syn_nz_q   <= |s_d;
            end
        end
    end

    assign syn_valid = syn_valid_q;
    assign syn_data  = syn_data_q;
    assign syn_nz    = syn_nz_q;

`ifdef GF3_SYN_ERRLOC_EN
    if (NSYN != 2) begin : g_bad_nsyn
        $error("GF3_SYN_ERRLOC_EN requires NSYN == 2");
    end

    logic [2:0] err_pos_q, err_pos_d;
    logic [2:0] err_mag_q, err_mag_d;
    logic       err_unc_q, err_unc_d;
    logic [2:0] l1, l2;
    int unsigned lp, lm;

    // Discrete log of a nonzero element
    function automatic logic [2:0] gf_log(input logic [2:0] a);
        case (a)
            3'b001:  return 3'd0;
            3'b010:  return 3'd1;
            3'b100:  return 3'd2;
            3'b011:  return 3'd3;
            3'b110:  return 3'd4;
            3'b111:  return 3'd5;
            3'b101:  return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // alpha^e for e in 0..6
    function automatic logic [2:0] gf_alog(input logic [2:0] e);
        case (e)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            3'd2:    return 3'b100;
            3'd3:    return 3'b011;
            3'd4:    return 3'b110;
            3'd5:    return 3'b111;
            3'd6:    return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    // Single-error locator: position = log(S2/S1), magnitude = S1^2/S2
    always_comb begin
        err_pos_d = 3'd0;
        err_mag_d = 3'd0;
        err_unc_d = 1'b0;
        l1        = gf_log(s_d[0]);
        l2        = gf_log(s_d[1]);
        lp        = (32'(l2) + 32'd7 - 32'(l1)) % 32'd7;
        lm        = (32'd2 * 32'(l1) + 32'd7 - 32'(l2)) % 32'd7;
        if ((s_d[0] == 3'd0) && (s_d[1] == 3'd0)) begin
            err_unc_d = 1'b0;
        end else if ((s_d[0] == 3'd0) || (s_d[1] == 3'd0)) begin
            err_unc_d = 1'b1;
        end else begin
            err_pos_d = 3'(lp);
            err_mag_d = gf_alog(3'(lm));
            err_unc_d = (lp >= N_SYM);
        end
    end

    // Locator registered alongside the syndromes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pos_q <= 3'd0;
            err_mag_q <= 3'd0;
            err_unc_q <= 1'b0;
        end else if (cap) begin
            err_pos_q <= err_pos_d;
            err_mag_q <= err_mag_d;
            err_unc_q <= err_unc_d;
        end
    end

    assign err_pos = err_pos_q;
    assign err_mag = err_mag_q;
    assign err_unc = err_unc_q;
`endif

endmodule

// File: tb/tb_gf3_rs_syndrome_seq.sv
// Bench for gf3_rs_syndrome_seq (N_SYM=7, NSYN=2): transaction model evaluating r(alpha^j) directly,
// per-cycle compare on the falling edge, plus hand-computed literal expectations.
module tb_gf3_rs_syndrome_seq;
    localparam int unsigned N = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [2:0] sym_data = 3'd0;
    logic       syn_valid;
    logic       syn_ready = 1'b1;
    logic [5:0] syn_data;
    logic       syn_nz;
`ifdef GF3_SYN_ERRLOC_EN
    logic [2:0] err_pos, err_mag;
    logic [0:0] err_unc;
`endif

    int checks = 0;
    int errors = 0;

    gf3_rs_syndrome_seq #(.N_SYM(7), .NSYN(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .syn_valid(syn_valid), .syn_ready(syn_ready),
        .syn_data(syn_data), .syn_nz(syn_nz)
`ifdef GF3_SYN_ERRLOC_EN
        , .err_pos(err_pos), .err_mag(err_mag), .err_unc(err_unc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Polynomial product mod x^3+x+1
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 0; i < 3; i++) if (b[i]) p ^= (6'(a) << i);
        for (int i = 4; i >= 3; i--) if (p[i]) p ^= (6'b001011 << (i - 3));
        return p[2:0];
    endfunction

    function automatic logic [2:0] alpha_pow(input int e);
        logic [2:0] r;
        r = 3'b001;
        for (int i = 0; i < (e % 7); i++) r = gf_mul(r, 3'b010);
        return r;
    endfunction

    // S_j = sum_k r_k * alpha^(j*k); w[k] is the degree-k coefficient
    function automatic logic [5:0] syndromes(input logic [6:0][2:0] w);
        logic [2:0] s1, s2;
        s1 = 3'd0;
        s2 = 3'd0;
        for (int k = 0; k < 7; k++) begin
            s1 ^= gf_mul(w[k], alpha_pow(k));
            s2 ^= gf_mul(w[k], alpha_pow(2 * k));
        end
        return {s2, s1};
    endfunction

    // Brute-force single-error search: returns {unc, mag, pos}
    function automatic logic [6:0] errloc(input logic [5:0] s);
        if (s == 6'd0) return 7'd0;
        for (int p = 0; p < 7; p++)
            for (int e = 1; e < 8; e++)
                if (gf_mul(3'(e), alpha_pow(p)) == s[2:0] && gf_mul(3'(e), alpha_pow(2 * p)) == s[5:3])
                    return {(p >= N) ? 1'b1 : 1'b0, 3'(e), 3'(p)};
        return 7'b1_000_000;
    endfunction

    // Transaction model driven only by bench inputs
    logic           m_valid;
    int             m_cnt;
    logic [5:0]     m_syn;
    logic [6:0][2:0] m_buf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            m_syn   = 6'd0;
        end else begin
            logic acc;
            acc = sym_valid && (!m_valid || syn_ready);
            if (flush) begin
                m_valid = 1'b0;
                m_cnt   = 0;
            end else begin
                if (m_valid && syn_ready) m_valid = 1'b0;
                if (acc) begin
                    m_buf[N - 1 - m_cnt] = sym_data;
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_syn   = syndromes(m_buf);
                        m_valid = 1'b1;
                        m_cnt   = 0;
                    end
                end
            end
        end
    end

    // Cycle compare against the model
    always @(negedge clk) begin
        chk("model_syn_valid", 32'(syn_valid), 32'(m_valid));
        chk("model_sym_ready", 32'(sym_ready), 32'(!m_valid || syn_ready));
        if (m_valid) begin
            chk("model_syn_data", 32'(syn_data), 32'(m_syn));
            chk("model_syn_nz", 32'(syn_nz), 32'(m_syn != 6'd0));
`ifdef GF3_SYN_ERRLOC_EN
            chk("model_errloc", 32'({err_unc, err_mag, err_pos}), 32'(errloc(m_syn)));
`endif
        end
    end

    // Send coefficients w[hi] down to w[0], one per cycle
    task automatic send_syms(input logic [6:0][2:0] w, input int hi);
        for (int k = hi; k >= 0; k--) begin
            sym_valid = 1'b1;
            sym_data  = w[k];
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        sym_data  = 3'd0;
    endtask

    task automatic check_lit(input string name, input logic [5:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, 32'(syn_valid), 32'd1);
        chk({name, "_data"}, 32'(syn_data), 32'(exp));
        chk({name, "_nz"}, 32'(syn_nz), 32'(exp != 6'd0));
    endtask

    logic [6:0][2:0] w;
    logic [6:0][2:0] wz;

    initial begin
        wz = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(syn_valid), 32'd0);
        chk("rst_data", 32'(syn_data), 32'd0);
        chk("rst_nz", 32'(syn_nz), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // All-zero codeword: pulse one cycle after the 7th accept
        send_syms(wz, 6);
        check_lit("zero", 6'b000_000);
        @(negedge clk);
        chk("zero_pulse_fall", 32'(syn_valid), 32'd0);

        w = '0; w[0] = 3'b101;
        send_syms(w, 6);
        check_lit("deg0", 6'b101_101);
`ifdef GF3_SYN_ERRLOC_EN
        chk("deg0_loc", 32'({err_unc, err_mag, err_pos}), 32'(7'b0_101_000));
`endif
        w = '0; w[1] = 3'b001;
        send_syms(w, 6);
        check_lit("deg1", 6'b100_010);
`ifdef GF3_SYN_ERRLOC_EN
        chk("deg1_loc", 32'({err_unc, err_mag, err_pos}), 32'(7'b0_001_001));
`endif
        w = '0; w[6] = 3'b001;
        send_syms(w, 6);
        check_lit("deg6", 6'b111_101);
`ifdef GF3_SYN_ERRLOC_EN
        chk("deg6_loc", 32'({err_unc, err_mag, err_pos}), 32'(7'b0_001_110));
`endif
        @(posedge clk); #1;

        // Stall in DONE with a symbol waiting, then release with no bubble
        syn_ready = 1'b0;
        w = '0; w[1] = 3'b001;
        send_syms(w, 6);
        sym_valid = 1'b1;
        sym_data  = 3'b011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(sym_ready), 32'd0);
            chk("stall_data", 32'(syn_data), 32'(6'b100_010));
        end
        @(posedge clk); #1 syn_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(sym_ready), 32'd1);
        @(posedge clk); #1;
        send_syms(wz, 5);
        check_lit("after_stall", 6'b010_100);
        @(posedge clk); #1;

        // Flush discards a partial codeword
        for (int i = 0; i < 3; i++) begin
            sym_valid = 1'b1; sym_data = 3'b111;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        send_syms(wz, 6);
        check_lit("flush", 6'b000_000);
        @(posedge clk); #1;

        // Nonzero result held, then async reset mid-codeword
        w = '0; w[3] = 3'b110;
        send_syms(w, 6);
        check_lit("pre_rst", syndromes(w));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            sym_valid = 1'b1; sym_data = 3'b010;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(syn_valid), 32'd0);
        chk("arst_data", 32'(syn_data), 32'd0);
        chk("arst_nz", 32'(syn_nz), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        w = '0; w[0] = 3'b101;
        send_syms(w, 6);
        check_lit("post_rst", 6'b101_101);

        // Back-to-back random codewords, model-checked
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 7; k++) w[k] = 3'($urandom_range(0, 7));
            send_syms(w, 6);
        end
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
